// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared encodings and defaults for the multiply/divide unit
// Purpose: md_op encodings, default latencies and the FSM state type.
// Ports: none (package).
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - EX-stage request/response bundle for the multiply/divide unit
// Purpose: groups the EX-side request (start, md_op, a, b) and the unit's
//          status/results (busy, start_seen, hi, lo).
// Ports:   master = EX datapath (drives request, reads status/results)
//          slave  = md_unit (reads request, drives status/results)
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        start_seen;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, a, b,
    input  busy, start_seen, hi, lo
  );

  modport slave (
    input  start, md_op, a, b,
    output busy, start_seen, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
// Purpose: executes mult/multu/div/divu with a fixed latency and mthi/mtlo in
//          one cycle. The result is computed combinationally in the start cycle,
//          parked in pend_hi/pend_lo and committed when the counter expires.
// Ports:   clk   - rising-edge clock
//          reset - synchronous, active-high; aborts any operation in flight
//          md    - md_unit_if.slave: start/md_op/a/b in; busy/start_seen/hi/lo out
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic     clk,
  input logic     reset,
  md_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_q, busy_n;
  logic [31:0]      hi_q, hi_n, lo_q, lo_n;
  logic [31:0]      pend_hi, pend_hi_n, pend_lo, pend_lo_n;

  // 64-bit operands; the divisor is forced to 1 when b==0 so the divider
  // never sees zero (that result is discarded anyway). Doing signed division
  // at 64 bits makes 0x80000000 / -1 land on 0x80000000 without overflow.
  logic signed [63:0] a_s64, b_s64, b_s64_safe;
  logic        [63:0] a_u64, b_u64_safe;
  logic        [63:0] prod_s, prod_u;
  logic        [31:0] quot_s, rem_s, quot_u, rem_u;

  always_comb begin
    a_s64      = {{32{md.a[31]}}, md.a};
    b_s64      = {{32{md.b[31]}}, md.b};
    b_s64_safe = (md.b == 32'd0) ? 64'sd1 : b_s64;
    a_u64      = {32'd0, md.a};
    b_u64_safe = (md.b == 32'd0) ? 64'd1 : {32'd0, md.b};
    prod_s     = a_s64 * b_s64;
    prod_u     = a_u64 * {32'd0, md.b};
    quot_s     = 32'(a_s64 / b_s64_safe);
    rem_s      = 32'(a_s64 % b_s64_safe);
    quot_u     = 32'(a_u64 / b_u64_safe);
    rem_u      = 32'(a_u64 % b_u64_safe);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      busy_q  <= busy_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    busy_n    = busy_q;
    hi_n      = hi_q;
    lo_n      = lo_q;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    case (state)
      ST_IDLE: begin
        if (md.start) begin
          case (md.md_op)
            MD_MULT, MD_MULTU: begin
              {pend_hi_n, pend_lo_n} = (md.md_op == MD_MULT) ? prod_s : prod_u;
              cnt_n   = CNT_W'(MULT_CYCLES - 1);
              busy_n  = 1'b1;
              state_n = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              if (md.b == 32'd0) begin
                // Divide by zero still costs the full latency but leaves HI/LO as is.
                pend_hi_n = hi_q;
                pend_lo_n = lo_q;
              end else if (md.md_op == MD_DIV) begin
                pend_hi_n = rem_s;
                pend_lo_n = quot_s;
              end else begin
                pend_hi_n = rem_u;
                pend_lo_n = quot_u;
              end
              cnt_n   = CNT_W'(DIV_CYCLES - 1);
              busy_n  = 1'b1;
              state_n = ST_BUSY;
            end
            MD_MTHI: hi_n = md.a;
            MD_MTLO: lo_n = md.a;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        // A start arriving here is ignored; the stall unit should never issue one.
        if (cnt == '0) begin
          hi_n    = pend_hi;
          lo_n    = pend_lo;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign md.busy       = busy_q;
  assign md.start_seen = md.start & ~busy_q;
  assign md.hi         = hi_q;
  assign md.lo         = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if mif();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy_cycles;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chkint(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: a response is a busy falling edge or a HI/LO change while idle.
  initial begin : monitor
    logic        rst_edge;
    logic        pbusy;
    logic [31:0] phi, plo;
    int          bcnt;
    exp_t        e;
    pbusy = 1'b0; phi = '0; plo = '0; bcnt = 0;
    forever begin
      @(posedge clk);
      rst_edge = reset;
      @(negedge clk);
      if (rst_edge) begin
        bcnt = 0;
      end else if (mif.busy) begin
        bcnt++;
        checks++;
        if (mif.hi !== phi || mif.lo !== plo) begin
          errors++;
          $display("FAIL hold_while_busy actual=%h_%h required=%h_%h", mif.hi, mif.lo, phi, plo);
        end
      end else if (pbusy || mif.hi !== phi || mif.lo !== plo) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response actual=%h_%h required=none", mif.hi, mif.lo);
        end else begin
          e = sbq.pop_front();
          chk32({e.name, "_hi"}, mif.hi, e.hi);
          chk32({e.name, "_lo"}, mif.lo, e.lo);
          chkint({e.name, "_busy_cycles"}, bcnt, e.busy_cycles);
        end
        bcnt = 0;
      end
      pbusy = mif.busy;
      phi   = mif.hi;
      plo   = mif.lo;
    end
  end

  // poke>0: pulse an mtlo start in busy cycle 'poke'; it must be ignored.
  task automatic issue(string name, logic [2:0] op, logic [31:0] av, logic [31:0] bv,
                       logic [31:0] eh, logic [31:0] el, int eb, int poke);
    exp_t e;
    e.hi = eh; e.lo = el; e.busy_cycles = eb; e.name = name;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    mif.start = 1'b1; mif.md_op = op; mif.a = av; mif.b = bv;
    @(negedge clk);
    chk32({name, "_start_seen"}, 32'(mif.start_seen), 32'd1);
    @(posedge clk);
    #1;
    mif.start = 1'b0; mif.a = 32'd0; mif.b = 32'd0;
    if (poke > 0) begin
      repeat (poke - 1) @(posedge clk);
      #1;
      mif.start = 1'b1; mif.md_op = MD_MTLO; mif.a = 32'h0000DEAD;
      @(negedge clk);
      chk32({name, "_poke_start_seen"}, 32'(mif.start_seen), 32'd0);
      @(posedge clk);
      #1;
      mif.start = 1'b0; mif.a = 32'd0;
    end
    repeat (eb + 2) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    mif.start = 1'b0; mif.md_op = MD_MULT; mif.a = 32'd0; mif.b = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk32("reset_busy", 32'(mif.busy), 32'd0);
    chk32("reset_hi", mif.hi, 32'd0);
    chk32("reset_lo", mif.lo, 32'd0);
    chk32("reset_start_seen", 32'(mif.start_seen), 32'd0);

    issue("mult",      MD_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 0);
    issue("multu",     MD_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5, 0);
    issue("div",       MD_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0);
    issue("divu",      MD_DIVU,  32'd7,        32'd2, 32'h00000001, 32'h00000003, 10, 0);
    issue("div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 0);
    issue("mthi",      MD_MTHI,  32'h00001234, 32'd0, 32'h00001234, 32'h80000000, 0, 0);
    issue("mtlo",      MD_MTLO,  32'h00005678, 32'd0, 32'h00001234, 32'h00005678, 0, 0);
    issue("div_by_0",  MD_DIV,   32'd99,       32'd0, 32'h00001234, 32'h00005678, 10, 0);

    // Abort a div 100/7 with reset sampled at the end of busy cycle 3.
    @(posedge clk);
    #1;
    mif.start = 1'b1; mif.md_op = MD_DIV; mif.a = 32'd100; mif.b = 32'd7;
    @(posedge clk);
    #1 mif.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk32("abort_busy", 32'(mif.busy), 32'd0);
    chk32("abort_hi", mif.hi, 32'd0);
    chk32("abort_lo", mif.lo, 32'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk32("abort_late_hi", mif.hi, 32'd0);
    chk32("abort_late_lo", mif.lo, 32'd0);

    issue("div_poked", MD_DIV,   32'd100,      32'd7, 32'h00000002, 32'h0000000E, 10, 3);
    issue("mult_pos",  MD_MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5, 0);

    repeat (3) @(posedge clk);
    chkint("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
